// File: rtl/l1_data_mem_responder_if.sv
// rtl/l1_data_mem_responder_if.sv - cache-side and memory-side bus bundle for l1_data_mem_responder
//
// Cache side : iDATA_REQ/oDATA_LOCK request handshake with ORDER/MASK/RW/ADDR/DATA fields,
//              oDATA_VALID/oDATA_DATA response beats.
// Memory side: oMEM_REQ/iMEM_BUSY issue handshake with RW/ADDR/BE/DATA fields,
//              iMEM_VALID/iMEM_DATA in-order responses.
// Status     : oERROR sticky protocol-error flag.
// slave  = responder view, master = cache + memory environment view.
interface l1_data_mem_responder_if;
    logic        iDATA_REQ;
    logic        oDATA_LOCK;
    logic [1:0]  iDATA_ORDER;
    logic [3:0]  iDATA_MASK;
    logic        iDATA_RW;
    logic [31:0] iDATA_ADDR;
    logic [31:0] iDATA_DATA;
    logic        oDATA_VALID;
    logic [63:0] oDATA_DATA;
    logic        oMEM_REQ;
    logic        iMEM_BUSY;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [7:0]  oMEM_BE;
    logic [63:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic [63:0] iMEM_DATA;
    logic        oERROR;

    modport slave (
        input  iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA,
        input  iMEM_BUSY, iMEM_VALID, iMEM_DATA,
        output oDATA_LOCK, oDATA_VALID, oDATA_DATA,
        output oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_BE, oMEM_DATA, oERROR
    );

    modport master (
        output iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA,
        output iMEM_BUSY, iMEM_VALID, iMEM_DATA,
        input  oDATA_LOCK, oDATA_VALID, oDATA_DATA,
        input  oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_BE, oMEM_DATA, oERROR
    );
endinterface

// File: rtl/l1_data_mem_responder.sv
// rtl/l1_data_mem_responder.sv - in-order memory responder for the L1 data cache data-memory port
//
// Ports:
//   iCLOCK      clock
//   inRESET     asynchronous active-low reset (also clears the drain counter)
//   iRESET_SYNC synchronous reset; memory requests already issued are drained and discarded
//   bus         l1_data_mem_responder_if.slave: cache request/response, memory issue/response, oERROR
// Requests are queued, issued to memory from the queue head, and each memory response is returned
// to the cache one cycle later as a 64b read beat or a zero write ack.
module l1_data_mem_responder #(
    parameter int P_QUEUE_DEPTH     = 8,
    parameter int P_MAX_OUTSTANDING = 8
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iRESET_SYNC,
    l1_data_mem_responder_if.slave   bus
);
    localparam int PW = $clog2(P_QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (P_MAX_OUTSTANDING > 1) ? $clog2(P_MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic        rw;
        logic [1:0]  order;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } req_t;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    req_t          q_mem [P_QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // One RW bit per issued-but-unanswered request, so responses know whether to carry data.
    logic          tag_mem [P_MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr, tag_rd;

    logic [3:0]    outstanding;
    logic [3:0]    drain;
    state_t        state;

    req_t          head;
    logic          push, pop, fwd, spurious;
    logic [3:0]    ost_nxt;
    logic          unused_head;

    assign head = q_mem[rd_ptr];

    // ORDER and the low address bits travel with the request for debug visibility only.
    assign unused_head = ^{head.order, head.addr[1:0]};

    assign bus.oDATA_LOCK = (count == CW'(P_QUEUE_DEPTH)) || (state == ST_DRAIN) || iRESET_SYNC;
    assign push           = bus.iDATA_REQ && !bus.oDATA_LOCK;

    assign bus.oMEM_REQ   = (count != '0) && (state == ST_RUN) &&
                            (outstanding < 4'(P_MAX_OUTSTANDING));
    assign pop            = bus.oMEM_REQ && !bus.iMEM_BUSY;

    assign bus.oMEM_RW    = head.rw;
    assign bus.oMEM_ADDR  = {head.addr[31:3], 3'h0};
    assign bus.oMEM_BE    = head.rw      ? 8'hFF :
                            head.addr[2] ? {head.mask, 4'h0} : {4'h0, head.mask};
    assign bus.oMEM_DATA  = head.rw      ? 64'h0 :
                            head.addr[2] ? {head.data, 32'h0} : {32'h0, head.data};

    // A response is only ours to forward while running with something outstanding; with
    // nothing outstanding and nothing to drain it is a protocol violation.
    assign fwd      = bus.iMEM_VALID && (state == ST_RUN) && (outstanding != 4'd0);
    assign spurious = bus.iMEM_VALID && (outstanding == 4'd0) && (drain == 4'd0);
    assign ost_nxt  = outstanding + 4'(pop) - 4'(fwd);

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(P_MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    always_ff @(posedge iCLOCK) begin
        if (push) begin
            q_mem[wr_ptr] <= '{rw: bus.iDATA_RW, order: bus.iDATA_ORDER, addr: bus.iDATA_ADDR,
                               mask: bus.iDATA_MASK, data: bus.iDATA_DATA};
        end
        if (pop) begin
            tag_mem[tag_wr] <= head.rw;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            tag_wr          <= '0;
            tag_rd          <= '0;
            outstanding     <= 4'd0;
            drain           <= 4'd0;
            state           <= ST_RUN;
            bus.oDATA_VALID <= 1'b0;
            bus.oDATA_DATA  <= 64'h0;
            bus.oERROR      <= 1'b0;
        end else if (iRESET_SYNC) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            tag_wr          <= '0;
            tag_rd          <= '0;
            outstanding     <= 4'd0;
            bus.oDATA_VALID <= 1'b0;
            bus.oDATA_DATA  <= 64'h0;
            bus.oERROR      <= 1'b0;
            if (state == ST_RUN) begin
                // Memory still owes us these answers; swallow them before accepting new work.
                drain <= ost_nxt;
                state <= (ost_nxt != 4'd0) ? ST_DRAIN : ST_RUN;
            end else if (bus.iMEM_VALID) begin
                drain <= drain - 4'd1;
                if (drain == 4'd1) state <= ST_RUN;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                tag_wr <= tag_next(tag_wr);
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= ost_nxt;

            if (fwd) begin
                tag_rd         <= tag_next(tag_rd);
                bus.oDATA_DATA <= tag_mem[tag_rd] ? bus.iMEM_DATA : 64'h0;
            end
            bus.oDATA_VALID <= fwd;

            if (spurious) bus.oERROR <= 1'b1;

            if ((state == ST_DRAIN) && bus.iMEM_VALID) begin
                drain <= drain - 4'd1;
                if (drain == 4'd1) state <= ST_RUN;
            end
        end
    end
endmodule

// File: tb/tb_l1_data_mem_responder.sv
// tb/tb_l1_data_mem_responder.sv - directed self-checking bench for l1_data_mem_responder
module tb_l1_data_mem_responder;
    logic iCLOCK = 1'b0;
    logic inRESET = 1'b0;
    logic iRESET_SYNC = 1'b0;

    l1_data_mem_responder_if bus();

    l1_data_mem_responder #(.P_QUEUE_DEPTH(8), .P_MAX_OUTSTANDING(8)) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    // Memory model: answers every issued request after 3 cycles when mem_auto=1,
    // otherwise the tasks inject responses by hand.
    bit          mem_auto = 1'b0;
    logic        auto_valid = 1'b0;
    logic [63:0] auto_data = 64'h0;
    logic        man_valid = 1'b0;
    logic [63:0] man_data = 64'h0;

    assign bus.iMEM_VALID = mem_auto ? auto_valid : man_valid;
    assign bus.iMEM_DATA  = mem_auto ? auto_data  : man_data;

    logic [63:0] got_q [$];
    logic        iss_rw [$];
    logic [31:0] iss_addr [$];
    logic [7:0]  iss_be [$];
    logic [63:0] iss_data [$];
    int          iss_cyc [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a + 32'h01000000};
    endfunction

    always @(posedge iCLOCK) cyc <= cyc + 1;

    always @(negedge iCLOCK) begin
        if (!inRESET) begin
            pend_addr.delete();
            pend_due.delete();
            auto_valid <= 1'b0;
        end else begin
            if (bus.oDATA_VALID) got_q.push_back(bus.oDATA_DATA);
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                auto_valid <= 1'b1;
                auto_data  <= mem_data(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                auto_valid <= 1'b0;
            end
            if (bus.oMEM_REQ && !bus.iMEM_BUSY) begin
                iss_rw.push_back(bus.oMEM_RW);
                iss_addr.push_back(bus.oMEM_ADDR);
                iss_be.push_back(bus.oMEM_BE);
                iss_data.push_back(bus.oMEM_DATA);
                iss_cyc.push_back(cyc);
                pend_addr.push_back(bus.oMEM_ADDR);
                pend_due.push_back(cyc + 3);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge iCLOCK);
        #1;
    endtask

    task automatic push(input logic rw, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, output logic acc);
        bus.iDATA_REQ   = 1'b1;
        bus.iDATA_RW    = rw;
        bus.iDATA_ADDR  = addr;
        bus.iDATA_MASK  = mask;
        bus.iDATA_DATA  = data;
        bus.iDATA_ORDER = 2'b11;
        @(negedge iCLOCK);
        acc = !bus.oDATA_LOCK;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle();
        bus.iDATA_REQ = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            cycles(1);
            k++;
        end
        if (got_q.size() < n) begin
            total++;
            $display("FAIL wait_got: have %0d responses, need %0d", got_q.size(), n);
        end
    endtask

    task automatic wait_iss(input int n, input int budget);
        int k = 0;
        while (iss_addr.size() < n && k < budget) begin
            cycles(1);
            k++;
        end
        if (iss_addr.size() < n) begin
            total++;
            $display("FAIL wait_iss: have %0d issues, need %0d", iss_addr.size(), n);
        end
    endtask

    task automatic do_reset();
        inRESET = 1'b0;
        man_valid = 1'b0;
        idle();
        cycles(3);
        inRESET = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge iCLOCK);
        total++; if (bus.oDATA_LOCK !== 1'b0) $display("FAIL reset_lock: got %b want 0", bus.oDATA_LOCK); else passed++;
        total++; if (bus.oDATA_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.oDATA_VALID); else passed++;
        total++; if (bus.oDATA_DATA !== 64'h0) $display("FAIL reset_data: got %h want 0", bus.oDATA_DATA); else passed++;
        total++; if (bus.oMEM_REQ !== 1'b0) $display("FAIL reset_memreq: got %b want 0", bus.oMEM_REQ); else passed++;
        total++; if (bus.oERROR !== 1'b0) $display("FAIL reset_error: got %b want 0", bus.oERROR); else passed++;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_line_fill();
        int gb = got_q.size();
        int ib = iss_addr.size();
        logic acc;
        logic lock_seen = 1'b0;
        mem_auto = 1'b1;
        bus.iMEM_BUSY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 32'h1000 + 32'(8 * i), 4'hF, 32'h0, acc);
            if (!acc) lock_seen = 1'b1;
        end
        idle();
        wait_got(gb + 8, 60);
        total++; if (lock_seen !== 1'b0) $display("FAIL fill_lock: lock seen %b want 0", lock_seen); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_q[gb + i] !== mem_data(32'h1000 + 32'(8 * i)))
                $display("FAIL fill_data[%0d]: got %h want %h", i, got_q[gb + i], mem_data(32'h1000 + 32'(8 * i)));
            else passed++;
            total++;
            if ({iss_addr[ib + i], iss_be[ib + i]} !== {32'h1000 + 32'(8 * i), 8'hFF})
                $display("FAIL fill_issue[%0d]: got %h/%h want %h/ff", i, iss_addr[ib + i], iss_be[ib + i], 32'h1000 + 32'(8 * i));
            else passed++;
        end
    endtask

    task automatic test_write();
        int gb = got_q.size();
        int ib = iss_addr.size();
        logic acc;
        mem_auto = 1'b1;
        push(1'b0, 32'h2004, 4'h3, 32'hAABBCCDD, acc);
        idle();
        wait_iss(ib + 1, 20);
        wait_got(gb + 1, 20);
        total++; if (iss_rw[ib] !== 1'b0) $display("FAIL wr_rw: got %b want 0", iss_rw[ib]); else passed++;
        total++; if (iss_addr[ib] !== 32'h2000) $display("FAIL wr_addr: got %h want 00002000", iss_addr[ib]); else passed++;
        total++; if (iss_be[ib] !== 8'h30) $display("FAIL wr_be: got %h want 30", iss_be[ib]); else passed++;
        total++; if (iss_data[ib] !== 64'hAABBCCDD_00000000) $display("FAIL wr_data: got %h want aabbccdd00000000", iss_data[ib]); else passed++;
        total++; if (got_q[gb] !== 64'h0) $display("FAIL wr_ack: got %h want 0", got_q[gb]); else passed++;
    endtask

    task automatic test_full();
        int gb = got_q.size();
        int ib = iss_addr.size();
        int bad = 0;
        logic acc;
        logic all_acc = 1'b1;
        logic lock9;
        mem_auto = 1'b1;
        bus.iMEM_BUSY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 32'h3000 + 32'(8 * i), 4'hF, 32'h0, acc);
            all_acc &= acc;
        end
        push(1'b1, 32'h3040, 4'hF, 32'h0, acc);
        lock9 = !acc;
        idle();
        total++; if (all_acc !== 1'b1) $display("FAIL full_accept8: got %b want 1", all_acc); else passed++;
        total++; if (lock9 !== 1'b1) $display("FAIL full_lock9: got %b want 1", lock9); else passed++;
        bus.iMEM_BUSY = 1'b0;
        wait_iss(ib + 8, 30);
        for (int i = 1; i < 8; i++)
            if (iss_cyc[ib + i] != iss_cyc[ib] + i) bad++;
        total++; if (bad !== 0) $display("FAIL full_b2b: %0d gaps want 0", bad); else passed++;
        wait_got(gb + 8, 60);
        cycles(5);
        total++; if (iss_addr.size() - ib !== 8) $display("FAIL full_count: got %0d issues want 8", iss_addr.size() - ib); else passed++;
        total++; if (got_q[gb + 7] !== mem_data(32'h3038)) $display("FAIL full_last: got %h want %h", got_q[gb + 7], mem_data(32'h3038)); else passed++;
    endtask

    task automatic test_outstanding_cap();
        int gb = got_q.size();
        int ib = iss_addr.size();
        logic acc;
        mem_auto = 1'b0;
        man_valid = 1'b0;
        for (int i = 0; i < 10; i++)
            push(1'b1, 32'h5000 + 32'(8 * i), 4'hF, 32'h0, acc);
        idle();
        cycles(20);
        total++; if (iss_addr.size() - ib !== 8) $display("FAIL cap_count: got %0d issues want 8", iss_addr.size() - ib); else passed++;
        @(negedge iCLOCK);
        total++; if (bus.oMEM_REQ !== 1'b0) $display("FAIL cap_memreq: got %b want 0", bus.oMEM_REQ); else passed++;
        @(posedge iCLOCK);
        #1;
        man_valid = 1'b1;
        man_data = mem_data(32'h5000);
        cycles(1);
        man_valid = 1'b0;
        cycles(4);
        total++; if (got_q.size() - gb !== 1) $display("FAIL cap_resp: got %0d responses want 1", got_q.size() - gb); else passed++;
        total++; if (got_q[gb] !== mem_data(32'h5000)) $display("FAIL cap_data: got %h want %h", got_q[gb], mem_data(32'h5000)); else passed++;
        total++; if (iss_addr.size() - ib !== 9) $display("FAIL cap_reissue: got %0d issues want 9", iss_addr.size() - ib); else passed++;
        do_reset();
    endtask

    task automatic test_sync_reset();
        int gb = got_q.size();
        int ib = iss_addr.size();
        logic acc;
        mem_auto = 1'b0;
        man_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            push(1'b1, 32'h6000 + 32'(8 * i), 4'hF, 32'h0, acc);
        idle();
        cycles(5);
        total++; if (iss_addr.size() - ib !== 3) $display("FAIL sync_issued: got %0d want 3", iss_addr.size() - ib); else passed++;
        iRESET_SYNC = 1'b1;
        @(negedge iCLOCK);
        total++; if (bus.oDATA_LOCK !== 1'b1) $display("FAIL sync_lock_pulse: got %b want 1", bus.oDATA_LOCK); else passed++;
        @(posedge iCLOCK);
        #1;
        iRESET_SYNC = 1'b0;
        @(negedge iCLOCK);
        total++; if (bus.oDATA_LOCK !== 1'b1) $display("FAIL sync_lock_drain: got %b want 1", bus.oDATA_LOCK); else passed++;
        @(posedge iCLOCK);
        #1;
        for (int r = 0; r < 3; r++) begin
            man_valid = 1'b1;
            man_data = mem_data(32'h6000 + 32'(8 * r));
            cycles(1);
            man_valid = 1'b0;
            @(negedge iCLOCK);
            total++;
            if (bus.oDATA_LOCK !== (r < 2)) $display("FAIL sync_lock_after_resp%0d: got %b want %b", r, bus.oDATA_LOCK, (r < 2));
            else passed++;
            @(posedge iCLOCK);
            #1;
        end
        cycles(2);
        total++; if (got_q.size() - gb !== 0) $display("FAIL sync_discard: got %0d responses want 0", got_q.size() - gb); else passed++;
        total++; if (bus.oERROR !== 1'b0) $display("FAIL sync_error: got %b want 0", bus.oERROR); else passed++;
        mem_auto = 1'b1;
        push(1'b1, 32'h7000, 4'hF, 32'h0, acc);
        idle();
        wait_got(gb + 1, 20);
        total++; if (got_q[gb] !== mem_data(32'h7000)) $display("FAIL sync_run_data: got %h want %h", got_q[gb], mem_data(32'h7000)); else passed++;
    endtask

    task automatic test_spurious();
        int gb;
        cycles(5);
        gb = got_q.size();
        mem_auto = 1'b0;
        man_valid = 1'b1;
        man_data = 64'h1234;
        cycles(1);
        man_valid = 1'b0;
        cycles(3);
        @(negedge iCLOCK);
        total++; if (got_q.size() - gb !== 0) $display("FAIL spur_fwd: got %0d responses want 0", got_q.size() - gb); else passed++;
        total++; if (bus.oERROR !== 1'b1) $display("FAIL spur_error: got %b want 1", bus.oERROR); else passed++;
        @(posedge iCLOCK);
        #1;
        cycles(10);
        @(negedge iCLOCK);
        total++; if (bus.oERROR !== 1'b1) $display("FAIL spur_sticky: got %b want 1", bus.oERROR); else passed++;
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b0;
        #2;
        total++; if (bus.oERROR !== 1'b0) $display("FAIL spur_clear: got %b want 0", bus.oERROR); else passed++;
        cycles(2);
        inRESET = 1'b1;
        cycles(1);
    endtask

    initial begin
        bus.iDATA_REQ   = 1'b0;
        bus.iDATA_ORDER = 2'b00;
        bus.iDATA_MASK  = 4'h0;
        bus.iDATA_RW    = 1'b0;
        bus.iDATA_ADDR  = 32'h0;
        bus.iDATA_DATA  = 32'h0;
        bus.iMEM_BUSY   = 1'b0;
        test_reset();
        test_line_fill();
        test_write();
        test_full();
        test_outstanding_cap();
        test_sync_reset();
        test_spurious();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
